// File: rtl/adma_wbm_arb.sv
// adma_wbm_arb: round-robin arbiter sharing the ADMA 64-bit Wishbone master between NREQ burst requesters
// Ports:
//   wb_clk_i, wb_rst_i (async, active-low)
//   req_i/req_we_i/req_adr_i/req_len_i/req_sel_i/req_dat_i : per-requester burst request and write data
//   gnt_o/beat_o/done_o/err_o/rd_dat_o                     : per-requester grant, beat strobe, termination, read data
//   wbm_*                                                  : Wishbone master bus
module adma_wbm_arb #(
    parameter int NREQ    = 4,
    parameter int LENW    = 8,
    parameter int MAX_RTY = 15
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ-1:0]      req_we_i,
    input  logic [NREQ*32-1:0]   req_adr_i,
    input  logic [NREQ*LENW-1:0] req_len_i,
    input  logic [NREQ*4-1:0]    req_sel_i,
    input  logic [NREQ*64-1:0]   req_dat_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      beat_o,
    output logic [NREQ-1:0]      done_o,
    output logic [NREQ-1:0]      err_o,
    output logic [63:0]          rd_dat_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_we_o,
    output logic                 wbm_cab_o,
    output logic [31:0]          wbm_adr_o,
    output logic [3:0]           wbm_sel_o,
    output logic [31:0]          wbm_dat_o,
    output logic [31:0]          wbm_dat64_o,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i,
    input  logic                 wbm_rty_i,
    input  logic [31:0]          wbm_dat_i,
    input  logic [31:0]          wbm_dat64_i
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int RW = $clog2(MAX_RTY + 2);

    typedef enum logic [2:0] {S_IDLE, S_BUS, S_DONE, S_ERR, S_RWAIT} state_t;

    state_t          r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_own;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_done;
    logic [NREQ-1:0] r_err;
    logic            r_cyc;
    logic            r_stb;
    logic            r_we;
    logic [31:0]     r_adr;
    logic [3:0]      r_sel;
    logic [LENW-1:0] r_cnt;
    logic [RW-1:0]   r_rty;

    logic            w_any;
    logic [IW-1:0]   w_win;
    logic            w_ack;
    logic [31:0]     w_adr [NREQ];
    logic [LENW-1:0] w_len [NREQ];
    logic [3:0]      w_sel [NREQ];
    logic [63:0]     w_dat [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_adr[g] = req_adr_i[g*32 +: 32];
        assign w_len[g] = req_len_i[g*LENW +: LENW];
        assign w_sel[g] = req_sel_i[g*4 +: 4];
        assign w_dat[g] = req_dat_i[g*64 +: 64];
    end

    // Scan downwards from the farthest slot so the requester closest to the pointer wins last.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_i[IW'((int'(r_ptr) + k) % NREQ)]) begin
                w_any = 1'b1;
                w_win = IW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_own   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_err   <= '0;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_rty   <= '0;
        end else begin
            r_done <= '0;
            r_err  <= '0;
            case (r_state)
                S_IDLE: if (w_any) begin
                    r_state <= S_BUS;
                    r_own   <= w_win;
                    r_ptr   <= (w_win == IW'(NREQ - 1)) ? '0 : w_win + 1'b1;
                    r_gnt   <= NREQ'(1) << w_win;
                    r_cyc   <= 1'b1;
                    r_stb   <= 1'b1;
                    r_we    <= req_we_i[w_win];
                    r_adr   <= w_adr[w_win];
                    r_sel   <= w_sel[w_win];
                    r_cnt   <= (w_len[w_win] == '0) ? LENW'(1) : w_len[w_win];
                    r_rty   <= '0;
                end
                // err outranks rty, rty outranks ack; the retry that exceeds the limit aborts.
                S_BUS: if (wbm_err_i || (wbm_rty_i && r_rty == RW'(MAX_RTY))) begin
                    r_state <= S_ERR;
                    r_cyc   <= 1'b0;
                    r_stb   <= 1'b0;
                    r_gnt   <= '0;
                    r_err   <= r_gnt;
                end else if (wbm_rty_i) begin
                    r_state <= S_RWAIT;
                    r_cyc   <= 1'b0;
                    r_stb   <= 1'b0;
                    r_rty   <= r_rty + 1'b1;
                end else if (wbm_ack_i) begin
                    r_adr <= r_adr + 32'd8;
                    r_cnt <= r_cnt - 1'b1;
                    r_rty <= '0;
                    if (r_cnt == LENW'(1)) begin
                        r_state <= S_DONE;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_gnt   <= '0;
                        r_done  <= r_gnt;
                    end
                end
                S_RWAIT: begin
                    r_state <= S_BUS;
                    r_cyc   <= 1'b1;
                    r_stb   <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_ack       = (r_state == S_BUS) && wbm_ack_i && !wbm_err_i && !wbm_rty_i;
    assign beat_o      = w_ack ? r_gnt : '0;
    assign rd_dat_o    = w_ack ? {wbm_dat64_i, wbm_dat_i} : '0;
    assign gnt_o       = r_gnt;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_stb;
    assign wbm_we_o    = r_cyc & r_we;
    assign wbm_cab_o   = r_stb && (r_cnt > LENW'(1));
    assign wbm_adr_o   = r_adr;
    assign wbm_sel_o   = r_sel;
    assign {wbm_dat64_o, wbm_dat_o} = (|r_gnt) ? w_dat[r_own] : '0;
endmodule

// File: tb/tb_adma_wbm_arb.sv
// tb_adma_wbm_arb: randomized scoreboard bench for adma_wbm_arb with a behavioural Wishbone slave and arbitration model
module tb_adma_wbm_arb;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req = '0;
    logic [3:0]   req_we = '0;
    logic [31:0]  a_adr [4];
    logic [7:0]   a_len [4];
    logic [3:0]   a_sel [4];
    logic [63:0]  a_dat [4];
    logic [127:0] req_adr;
    logic [31:0]  req_len;
    logic [15:0]  req_sel;
    logic [255:0] req_dat;
    logic         ack = 1'b0, err = 1'b0, rty = 1'b0;
    logic [31:0]  di = '0, di64 = '0;
    logic [3:0]   gnt, beat, done, errp, sel;
    logic [63:0]  rd;
    logic         cyc, stb, we, cab;
    logic [31:0]  adr, dlo, dhi;

    assign req_adr = {a_adr[3], a_adr[2], a_adr[1], a_adr[0]};
    assign req_len = {a_len[3], a_len[2], a_len[1], a_len[0]};
    assign req_sel = {a_sel[3], a_sel[2], a_sel[1], a_sel[0]};
    assign req_dat = {a_dat[3], a_dat[2], a_dat[1], a_dat[0]};

    always #5 clk = ~clk;

    adma_wbm_arb dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .req_i(req), .req_we_i(req_we), .req_adr_i(req_adr), .req_len_i(req_len),
        .req_sel_i(req_sel), .req_dat_i(req_dat),
        .gnt_o(gnt), .beat_o(beat), .done_o(done), .err_o(errp), .rd_dat_o(rd),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_cab_o(cab),
        .wbm_adr_o(adr), .wbm_sel_o(sel), .wbm_dat_o(dlo), .wbm_dat64_o(dhi),
        .wbm_ack_i(ack), .wbm_err_i(err), .wbm_rty_i(rty),
        .wbm_dat_i(di), .wbm_dat64_i(di64)
    );

    int          n_chk = 0, n_fail = 0;
    logic [3:0]  pend = '0, drop = '0, adv = '0;
    logic [1:0]  mptr = '0, own = '0;
    int          rem = 0, rcnt = 0;
    logic [31:0] madr = '0;
    bit          active = 0, gap = 0, storm = 0, run = 0, gen = 0;
    logic [3:0]  pg = '0;
    int          q_gnt [$];
    logic [65:0] q_beat [$];
    logic [2:0]  q_term [$];

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic unexp(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: DUT output with no expected entry", nm);
    endtask

    // Round-robin reference: first pending requester at or after the pointer.
    function automatic int rr_pick(input logic [3:0] p, input logic [1:0] ptr);
        for (int k = 0; k < 4; k++) begin
            logic [1:0] j;
            j = ptr + 2'(k);
            if (p[j]) return int'(j);
        end
        return -1;
    endfunction

    task automatic raise(input logic [1:0] i);
        int l;
        l = $urandom_range(0, 5);
        a_len[i] = (l == 5) ? 8'd9 : 8'(l);
        a_adr[i] = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFF8);
        a_sel[i] = 4'($urandom);
        a_dat[i] = {$urandom, $urandom};
        req_we[i] = 1'($urandom);
        req[i] = 1'b1;
        pend[i] = 1'b1;
    endtask

    task automatic term(input logic e);
        q_term.push_back({e, own});
        active = 1'b0;
        drop[own] = 1'b1;
        gap = 1'b1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((active || pend != 0 || req != 0 || q_gnt.size() + q_beat.size() + q_term.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: bus still busy after %0d cycles", t);
        end
        repeat (3) @(negedge clk);
    endtask

    // Stimulus: requesters and Wishbone slave; expected responses are queued for the monitor.
    initial begin
        int w, r;
        bit was;
        logic [3:0] just;
        forever begin
            @(posedge clk);
            #1;
            if (!run) continue;
            for (int i = 0; i < 4; i++) if (adv[i]) a_dat[i] = {$urandom, $urandom};
            adv = '0;
            just = drop;
            req = req & ~drop;
            drop = '0;
            was = active;
            #1;
            ack = 1'b0;
            err = 1'b0;
            rty = 1'b0;
            if (gap) begin
                chk("gap_cyc", cyc, 0);
                gap = 1'b0;
                ack = ($urandom_range(0, 2) == 0);
            end else if (cyc && stb) begin
                if (!active) begin
                    w = rr_pick(pend, mptr);
                    if (w < 0) unexp("grant_without_request");
                    else begin
                        q_gnt.push_back(w);
                        own = 2'(w);
                        pend[own] = 1'b0;
                        mptr = own + 2'd1;
                        active = 1'b1;
                        rem = (a_len[own] == 0) ? 1 : int'(a_len[own]);
                        madr = a_adr[own];
                        rcnt = 0;
                        storm = ($urandom_range(0, 7) == 0);
                    end
                end
                if (active) begin
                    chk("adr", adr, madr);
                    chk("sel", sel, a_sel[own]);
                    chk("we", we, req_we[own]);
                    chk("cab", cab, 64'(rem > 1));
                    if (req_we[own]) chk("wr_dat", {dhi, dlo}, a_dat[own]);
                    r = storm ? 2 : $urandom_range(0, 19);
                    if (r == 0) begin
                        err = 1'b1;
                        rty = 1'($urandom);
                        ack = 1'($urandom);
                        term(1'b1);
                    end else if (r < 5) begin
                        rty = 1'b1;
                        ack = 1'($urandom);
                        rcnt++;
                        if (rcnt > 15) term(1'b1);
                        else gap = 1'b1;
                    end else if (r >= 8) begin
                        ack = 1'b1;
                        di = $urandom;
                        di64 = $urandom;
                        q_beat.push_back({own, di64, di});
                        adv[own] = 1'b1;
                        madr = madr + 32'd8;
                        rem--;
                        rcnt = 0;
                        if (rem == 0) term(1'b0);
                    end
                end
            end else begin
                if (active) chk("cyc_held", cyc, 1);
                ack = ($urandom_range(0, 2) == 0);
            end
            if (gen) begin
                if (was) begin
                    for (int i = 0; i < 4; i++) if (!req[i] && $urandom_range(0, 5) == 0) raise(2'(i));
                end else if (!active && pend == 0 && req == 0) begin
                    for (int i = 0; i < 4; i++) if (!just[i] && $urandom_range(0, 1) == 1) raise(2'(i));
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a grant, beat or termination.
    initial begin
        int g;
        logic [65:0] b;
        logic [2:0] t;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pg = '0;
                continue;
            end
            if (gnt != 0 && pg == 0) begin
                if (q_gnt.size() == 0) unexp("gnt");
                else begin
                    g = q_gnt.pop_front();
                    chk("gnt", gnt, 4'b1 << g);
                end
            end
            pg = gnt;
            if (beat != 0) begin
                if (q_beat.size() == 0) unexp("beat");
                else begin
                    b = q_beat.pop_front();
                    chk("beat", beat, 4'b1 << b[65:64]);
                    chk("rd_dat", rd, b[63:0]);
                end
            end
            if ((done | errp) != 0) begin
                if (q_term.size() == 0) unexp("term");
                else begin
                    t = q_term.pop_front();
                    chk("done", done, t[2] ? 4'b0 : 4'b1 << t[1:0]);
                    chk("err", errp, t[2] ? 4'b1 << t[1:0] : 4'b0);
                    chk("gnt_off", gnt, 0);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            a_adr[i] = '0;
            a_len[i] = '0;
            a_sel[i] = '0;
            a_dat[i] = '0;
        end
        #2;
        chk("rst_cyc", cyc, 0);
        chk("rst_stb", stb, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_beat", beat, 0);
        chk("rst_done", done, 0);
        chk("rst_err", errp, 0);
        chk("rst_adr", adr, 0);
        chk("rst_cab", cab, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run = 1;
        gen = 1;
        repeat (4000) @(posedge clk);
        gen = 0;
        drain();
        @(negedge clk);
        raise(2'd0);
        raise(2'd3);
        a_len[0] = 8'd8;
        a_len[3] = 8'd8;
        begin
            int t;
            t = 0;
            while (!active && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!active) unexp("no_grant_before_reset");
        end
        repeat (3) @(negedge clk);
        #2;
        run = 0;
        ack = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst_cyc", cyc, 0);
        chk("midrst_stb", stb, 0);
        chk("midrst_gnt", gnt, 0);
        chk("midrst_beat", beat, 0);
        chk("midrst_done", done, 0);
        chk("midrst_err", errp, 0);
        q_gnt.delete();
        q_beat.delete();
        q_term.delete();
        active = 0;
        gap = 0;
        drop = '0;
        adv = '0;
        mptr = '0;
        pend = req;
        ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run = 1;
        drain();
        chk("queues_empty", 64'(q_gnt.size() + q_beat.size() + q_term.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
